// File: rtl/minisys_fetch_stage.sv
// MiniSys instruction-fetch stage: owns the PC, runs a single-outstanding
// request/response handshake to instruction memory and drives the IF/ID register.
module minisys_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic        jumpI,
  input  logic [31:0] pc_jumpI,
  input  logic        branchE,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic [31:0] pcF
);

  typedef enum logic [1:0] {REQ, WAIT, FULL} fetchState_t;

  fetchState_t state, stateNext;
  logic        drop, dropNext;
  logic [31:0] pc, pcNext, pcPlus4;
  logic [31:0] bufInstr, bufPc4;
  logic        bufLoad;
  logic        deliver;
  logic [31:0] deliverInstr, deliverPc4;
  logic        redir;
  logic [31:0] target;

  // branchE wins over jumpI; targets are always word aligned.
  assign redir     = branchE | jumpI;
  assign target    = (branchE ? branch_target : pc_jumpI) & 32'hFFFF_FFFC;
  assign pcPlus4   = pc + 32'd4;
  assign imem_addr = {pc[31:2], 2'b00};
  assign pcF       = pc;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    stateNext    = state;
    dropNext     = drop;
    pcNext       = pc;
    imem_req     = 1'b0;
    bufLoad      = 1'b0;
    deliver      = 1'b0;
    deliverInstr = imem_rdata;
    deliverPc4   = pcPlus4;
    case (state)
      REQ: begin
        imem_req = !redir;
        if (redir) begin
          pcNext = target;
          if (imem_gnt) begin
            stateNext = WAIT;
            dropNext  = 1'b1;
          end
        end else if (imem_gnt) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop || redir) begin
            dropNext  = 1'b0;
            stateNext = REQ;
            if (redir) pcNext = target;
          end else if (!stall) begin
            deliver   = 1'b1;
            pcNext    = pcPlus4;
            stateNext = REQ;
          end else begin
            bufLoad   = 1'b1;
            stateNext = FULL;
          end
        end else if (redir) begin
          // The in-flight response still has to come back; mark it wrong-path.
          pcNext   = target;
          dropNext = 1'b1;
        end
      end
      FULL: begin
        if (redir) begin
          pcNext    = target;
          stateNext = REQ;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliverInstr = bufInstr;
          deliverPc4   = bufPc4;
          pcNext       = bufPc4;
          stateNext    = REQ;
        end
      end
      default: stateNext = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates together at the edge.
    if (!clrn) begin
      state <= REQ;
      drop  <= 1'b0;
      pc    <= RESET_PC;
    end else begin
      state <= stateNext;
      drop  <= dropNext;
      pc    <= pcNext;
    end
  end

  // NOTE: the skid buffer is only read in FULL, after it has been written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bufLoad) begin
      bufInstr <= imem_rdata;
      bufPc4   <= pcPlus4;
    end
  end

  // IF/ID register: redirect bubbles even through a stall; idle cycles insert a NOP.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      instrD   <= '0;
      pcplus4D <= '0;
    end else if (redir) begin
      instrD   <= '0;
      pcplus4D <= '0;
    end else if (!stall) begin
      if (deliver) begin
        instrD   <= deliverInstr;
        pcplus4D <= deliverPc4;
      end else begin
        instrD <= '0;
      end
    end
  end

endmodule
